// File: rtl/led_color_mixer_seq.sv
// led_color_mixer_seq
// Maps a progress index onto a red -> yellow -> green status colour.
// The channel ratio delta*CMAX/den is computed by an iterative restoring
// divider (one quotient bit per clock), so the result appears a fixed number
// of cycles after a request is accepted, independent of the operand values.
// Optional feature macro: BRIGHTNESS_EN adds a 'brilho' input and a SCALE
// state that dims every channel by (brilho+1)/2^COLOR_W.
module led_color_mixer_seq #(
  parameter int N       = 10,
  parameter int COLOR_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N-1:0]           contador,
  input  logic [N-1:0]           mid_idx,
  input  logic [N-1:0]           max_idx,
`ifdef BRIGHTNESS_EN
  input  logic [COLOR_W-1:0]     brilho,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [3*COLOR_W-1:0]   cor_led
);

  localparam int W  = N + COLOR_W;
  localparam int CW = $clog2(W);

  localparam logic [COLOR_W-1:0] CMAX   = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] CZERO  = {COLOR_W{1'b0}};
  localparam logic [W-1:0]       CMAX_W = {{N{1'b0}}, CMAX};
  localparam logic [W-1:0]       ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      LAST   = CW'(W - 1);

`ifdef BRIGHTNESS_EN
  typedef enum logic [1:0] {IDLE, DIV, SCALE, FIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;
`endif

  state_t state;

  logic              lt_q;
  logic              eq_q;
  logic [W-1:0]      num_q;
  logic [W-1:0]      den_q;
  logic [W-1:0]      rem_q;
  logic [CW-1:0]     bit_cnt;

  logic [N-1:0]      delta_in;
  logic [W-1:0]      den_in;
  logic [W-1:0]      num_in;

  logic [W:0]        rem_shift;
  logic [W:0]        rem_diff;
  logic              take;

  logic [COLOR_W-1:0]   q_sat;
  logic [3*COLOR_W-1:0] color_raw;

`ifdef BRIGHTNESS_EN
  logic [COLOR_W-1:0]   brilho_q;
  logic [3*COLOR_W-1:0] col_q;

  // Dim one channel: (c*(b+1)) >> COLOR_W, so b = CMAX leaves c unchanged.
  function automatic logic [COLOR_W-1:0] scale_ch(input logic [COLOR_W-1:0] c,
                                                  input logic [COLOR_W-1:0] b);
    logic [2*COLOR_W-1:0] p;
    p = {{COLOR_W{1'b0}}, c} * ({{COLOR_W{1'b0}}, b} + {{(2*COLOR_W-1){1'b0}}, 1'b1});
    return COLOR_W'(p >> COLOR_W);
  endfunction
`endif

  // Select the segment of the ramp and form numerator/denominator from the live inputs.
  always_comb begin
    delta_in = '0;
    den_in   = ONE_W;
    if (contador < mid_idx) begin
      delta_in = contador;
      den_in   = {{COLOR_W{1'b0}}, mid_idx};
    end else if (contador > mid_idx) begin
      delta_in = contador - mid_idx;
      den_in   = (max_idx > mid_idx) ? {{COLOR_W{1'b0}}, max_idx - mid_idx} : ONE_W;
    end
    num_in = {{COLOR_W{1'b0}}, delta_in} * CMAX_W;
  end

  // One restoring-division step; the borrow bit of the trial subtraction decides the quotient bit.
  always_comb begin
    rem_shift = {rem_q, num_q[W-1]};
    rem_diff  = rem_shift - {1'b0, den_q};
    take      = ~rem_diff[W];
  end

  // Saturate the quotient to a channel value and place it on the ramp.
  always_comb begin
    q_sat = (|num_q[W-1:COLOR_W]) ? CMAX : num_q[COLOR_W-1:0];
    if (eq_q) begin
      color_raw = {CMAX, CMAX, CZERO};
    end else if (lt_q) begin
      color_raw = {CMAX, q_sat, CZERO};
    end else begin
      color_raw = {CMAX - q_sat, CMAX, CZERO};
    end
  end

  // Control FSM with registered handshake outputs and the divider datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cor_led  <= '0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      num_q    <= '0;
      den_q    <= '0;
      rem_q    <= '0;
      bit_cnt  <= '0;
`ifdef BRIGHTNESS_EN
      brilho_q <= '0;
      col_q    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lt_q     <= (contador < mid_idx);
            eq_q     <= (contador == mid_idx);
            num_q    <= num_in;
            den_q    <= den_in;
            rem_q    <= '0;
            bit_cnt  <= '0;
`ifdef BRIGHTNESS_EN
            brilho_q <= brilho;
`endif
            busy     <= 1'b1;
            state    <= DIV;
          end
        end
        DIV: begin
          rem_q   <= take ? rem_diff[W-1:0] : rem_shift[W-1:0];
          num_q   <= {num_q[W-2:0], take};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST) begin
`ifdef BRIGHTNESS_EN
            state <= SCALE;
`else
            state <= FIN;
`endif
          end
        end
`ifdef BRIGHTNESS_EN
        SCALE: begin
          col_q <= {scale_ch(color_raw[3*COLOR_W-1:2*COLOR_W], brilho_q),
                    scale_ch(color_raw[2*COLOR_W-1:COLOR_W],   brilho_q),
                    scale_ch(color_raw[COLOR_W-1:0],           brilho_q)};
          state <= FIN;
        end
`endif
        FIN: begin
`ifdef BRIGHTNESS_EN
          cor_led <= col_q;
`else
          cor_led <= color_raw;
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
